add_one_arbiter: RTL and testbench
==================================

Name: add_one_arbiter

Overview:
- Shares one registered add-one (increment) unit between N_REQ requesters.
- Round-robin grant; per-requester valid/ready request ports; a single valid/ready response port tagged with the requester ID.
- Sits in front of the increment datapath, so several producers can use one incrementer without contention.

Parameters:
- WIDTH, 8, operand and result width in bits.
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the response tag.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_data  input  N_REQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  one-hot grant; at most one bit is high in any cycle.
- resp_valid  output  1  result available.
- resp_data  output  WIDTH  operand + 1.
- resp_id  output  ID_W  index of the requester that owns resp_data.
- resp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0.
  - resp_valid=0, resp_data=0, resp_id=0, req_ready=0 while reset is high.
  - Reset asserted mid-transaction discards any held result; the requester must not treat an unreturned request as served.
- States:
  - IDLE: no result held.
  - BUSY: result held on the resp_* outputs.
- Grant selection (combinational):
  - Scan req_valid starting at rr_ptr, upward with wrap modulo N_REQ. The first set bit is g.
  - If no bit is set, there is no grant.
- can_accept = (state==IDLE) or (state==BUSY and resp_ready).
- req_ready[g] = can_accept and a grant exists; all other bits are 0.
  - req_ready never depends on req_valid of a non-granted requester.
- Accept (req_valid[g] and req_ready[g] at a clock edge):
  - resp_data <= req_data[g] + 1, modulo 2^WIDTH (0xFF -> 0x00 for WIDTH=8).
  - resp_id <= g; resp_valid <= 1; state <= BUSY.
  - rr_ptr <= (g+1) mod N_REQ.
- Latency: the result appears the cycle after the accept edge, so there is 1 cycle from request handshake to resp_valid.
- In BUSY with resp_ready=0:
  - resp_* hold stable; req_ready=0 (backpressure).
- In BUSY with resp_ready=1:
  - The response completes.
  - With a simultaneous new grant: stay BUSY and load the new result. This gives 1 op/cycle throughput.
  - With no grant: resp_valid <= 0, state <= IDLE. resp_data and resp_id keep their last value.
- rr_ptr is unchanged in any cycle without an accept.
- Requester rules:
  - Once a requester raises req_valid, it holds req_valid and req_data stable until req_ready.
  - The arbiter guarantees a waiting requester is served within N_REQ accepts.
- Simultaneous requests are granted strictly in round-robin order from rr_ptr.
  - Example: rr_ptr=0 and all valid gives grants in the order 0,1,2,3,0.

Optional Feature:
- Macro: ADD_ONE_ARBITER_SATURATE_EN.
- Defined: the result saturates at the maximum value, so 0xFF -> 0xFF for WIDTH=8; all other values get +1.
- Not defined: wrap-around, 0xFF -> 0x00.
- No port or timing difference between the two builds.

Test Plan:
- Reset then idle: hold reset high for 2 cycles, then release with all req_valid=0 -> resp_valid=0, req_ready=0, resp_data=0 on every cycle.
- Single requester: req_valid=4'b0100, data[2]=0x10, resp_ready=1 -> req_ready=4'b0100 in the same cycle; next cycle resp_valid=1, resp_data=0x11, resp_id=2.
- Round-robin fairness: all four valid, data i = 17*i, resp_ready=1 continuously, held for 8 accepts -> resp_id sequence 0,1,2,3,0,1,2,3; resp_data 0x01,0x12,0x23,0x34 repeating; one result per cycle.
- Backpressure: one result pending with resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0 for those cycles; when resp_ready=1, the next grant is issued in that same cycle.
- Wrap/saturate: requester 1 sends 0xFF -> resp_data=0x00 without the macro, 0xFF with ADD_ONE_ARBITER_SATURATE_EN. Sweep x = 0,17,34,…, 256 ops, each checked against x+1 mod 256.
- Reset mid-operation: assert reset while BUSY with resp_ready=0 -> resp_valid falls immediately without waiting for a clock edge; after release, rr_ptr=0 and requester 0 is granted first.

Source files
------------

// File: rtl/add_one_arbiter.sv
// Round-robin arbiter sharing one registered add-one unit between N_REQ requesters.
// Build option: define ADD_ONE_ARBITER_SATURATE_EN to saturate at the maximum value instead of wrapping.
module add_one_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id,
    input  logic                   resp_ready,
    output logic                   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid/data stable until then, and ready
    // never depends on valid of a requester other than the granted one.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  result;
    int                scan_idx;

    // First set req_valid bit at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Reset gates ready combinationally so no grant is visible while it is held.
    assign can_accept = !reset && ((state_q == IDLE) || resp_ready);
    assign accept     = can_accept && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign operand = req_data[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef ADD_ONE_ARBITER_SATURATE_EN
    assign result = (&operand) ? operand : operand + WIDTH'(1);
`else
    assign result = operand + WIDTH'(1);
`endif

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = BUSY;
        end else if (state_q == BUSY && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                resp_data <= result;
                resp_id   <= grant_idx;
                if (int'(grant_idx) == N_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

    // Derived from the state register so async reset clears it immediately.
    assign resp_valid = (state_q == BUSY);
    assign dbg_state  = (state_q == BUSY);

endmodule

// File: tb/tb_add_one_arbiter.sv
// Directed testbench for add_one_arbiter: vector table, backpressure, mid-op reset and a 256-value sweep.
// Expected results follow ADD_ONE_ARBITER_SATURATE_EN when it is defined.
module tb_add_one_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_ready;
    logic                   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [ID_W+WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [N_REQ-1:0]       valid;
        logic [N_REQ*WIDTH-1:0] data;
        logic                   rready;
        logic [N_REQ-1:0]       exp_rdy;
        logic                   exp_rv;
        logic [WIDTH-1:0]       exp_d;
        logic [ID_W-1:0]        exp_id;
    } vec_t;

    vec_t vecs[17];

    add_one_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] inc_model(input logic [WIDTH-1:0] x);
`ifdef ADD_ONE_ARBITER_SATURATE_EN
        return (x == 8'hFF) ? 8'hFF : x + 8'd1;
`else
        return x + 8'd1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N_REQ-1:0] v, input logic [N_REQ*WIDTH-1:0] d, input logic rr);
        @(posedge clk);
        #1;
        req_valid  = v;
        req_data   = d;
        resp_ready = rr;
    endtask

    task automatic check_outputs(input string tag, input logic [N_REQ-1:0] rdy, input logic rv,
                                 input logic [WIDTH-1:0] d, input logic [ID_W-1:0] id);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'(rv));
        check({tag, "_resp_data"}, 32'(resp_data), 32'(d));
        check({tag, "_resp_id"}, 32'(resp_id), 32'(id));
    endtask

    initial begin
        logic [N_REQ*WIDTH-1:0] sweep_d;
        logic [ID_W+WIDTH-1:0]  got;
        logic [ID_W+WIDTH-1:0]  want;
        int                     r;
        logic [WIDTH-1:0]       x;

        // Reset state, round-robin, single requester, wrap, fairness from a moved pointer.
        vecs[0]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
        vecs[2]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd0};
        vecs[3]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd1};
        vecs[4]  = '{4'b1111, 32'h33221100, 1'b1, 4'b1000, 1'b1, 8'h23, 2'd2};
        vecs[5]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0001, 1'b1, 8'h34, 2'd3};
        vecs[6]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd0};
        vecs[7]  = '{4'b1111, 32'h33221100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd1};
        vecs[8]  = '{4'b1111, 32'h33221100, 1'b1, 4'b1000, 1'b1, 8'h23, 2'd2};
        vecs[9]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h34, 2'd3};
        vecs[10] = '{4'b0100, 32'h00100000, 1'b1, 4'b0100, 1'b0, 8'h34, 2'd3};
        vecs[11] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd2};
        vecs[12] = '{4'b0010, 32'h0000FF00, 1'b1, 4'b0010, 1'b0, 8'h11, 2'd2};
        vecs[13] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, inc_model(8'hFF), 2'd1};
        vecs[14] = '{4'b1001, 32'h3300005A, 1'b1, 4'b1000, 1'b0, inc_model(8'hFF), 2'd1};
        vecs[15] = '{4'b0001, 32'h3300005A, 1'b1, 4'b0001, 1'b1, 8'h34, 2'd3};
        vecs[16] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h5B, 2'd0};

        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 4'b0000, 1'b0, 8'h00, 2'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].rready);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_rv, vecs[i].exp_d, vecs[i].exp_id);
        end

        // Backpressure: result held 5 cycles, then handed over with a same-cycle grant.
        drive(4'b0010, 32'h00004000, 1'b0);
        @(negedge clk);
        check_outputs("bp_first", 4'b0010, 1'b0, 8'h5B, 2'd0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 32'h00500000, 1'b0);
            @(negedge clk);
            check_outputs($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 8'h41, 2'd1);
        end
        drive(4'b0100, 32'h00500000, 1'b1);
        @(negedge clk);
        check_outputs("bp_release", 4'b0100, 1'b1, 8'h41, 2'd1);
        drive(4'b0000, 32'h00000000, 1'b1);
        @(negedge clk);
        check_outputs("bp_next", 4'b0000, 1'b1, 8'h51, 2'd2);

        // Reset while BUSY under backpressure; pointer moved to 2 beforehand.
        drive(4'b0010, 32'h00007A00, 1'b0);
        @(negedge clk);
        check_outputs("rst_accept", 4'b0010, 1'b0, 8'h51, 2'd2);
        drive(4'b1111, 32'h33221100, 1'b0);
        @(negedge clk);
        check_outputs("rst_busy", 4'b0000, 1'b1, 8'h7B, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("rst_async", 4'b0000, 1'b0, 8'h00, 2'd0);
        check("rst_async_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check_outputs("rst_first_grant", 4'b0001, 1'b0, 8'h00, 2'd0);
        drive(4'b0000, 32'h00000000, 1'b1);
        @(negedge clk);
        check_outputs("rst_first_resp", 4'b0000, 1'b1, 8'h01, 2'd0);

        // Sweep all 256 operands through rotating requesters at one op per cycle.
        for (int k = 0; k < 256; k++) begin
            r = k % N_REQ;
            x = WIDTH'((17 * k) % 256);
            sweep_d = '0;
            sweep_d[r*WIDTH +: WIDTH] = x;
            drive(N_REQ'(1 << r), sweep_d, 1'b1);
            @(negedge clk);
            check("sweep_req_ready", 32'(req_ready), 32'(1 << r));
            if (k > 0) begin
                check("sweep_resp_valid", 32'(resp_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    check("sweep_queue_underflow", 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    got  = {resp_id, resp_data};
                    check("sweep_resp", 32'(got), 32'(want));
                end
            end
            exp_q.push_back({ID_W'(r), inc_model(x)});
        end
        drive(4'b0000, 32'h00000000, 1'b1);
        @(negedge clk);
        check("sweep_last_valid", 32'(resp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check("sweep_last_underflow", 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            got  = {resp_id, resp_data};
            check("sweep_last_resp", 32'(got), 32'(want));
        end
        @(negedge clk);
        check("sweep_idle", 32'(resp_valid), 32'd0);
        check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
